bus_trace: RTL

//  Downstream consumer of the synchronised 6502 bus (PHI2/A/D/RW/SYNC after the 2-FF syncs in top).

---
 rtl/bus_trace_pkg.sv | 18 +
 rtl/trace_ram.sv | 30 +++
 rtl/bus_trace.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// Shared record layout for the bus trace history.
// A record is packed as {a, d, rw, sync}, with sync in bit 0.
package bus_trace_pkg;

   localparam int REC_W    = 26;
   localparam int REC_SYNC = 0;
   localparam int REC_RW   = 1;
   localparam int REC_D    = 2;
   localparam int REC_A    = 10;

   function automatic logic [REC_W-1:0] pack_rec(input logic [15:0] a,
                                                  input logic [7:0]  d,
                                                  input logic        rw,
                                                  input logic        sync);
      return {a, d, rw, sync};
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port history RAM.
// Writes are synchronous. Reads are synchronous and registered.
// A read of the address being written returns the old contents.
module trace_ram #(
   parameter int AW = 4,
   parameter int DW = 26
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // write port; contents are not reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read port; the output register clears so outputs read 0 in reset
   always_ff @(posedge clk) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/bus_trace.sv
// 6502 bus cycle tracer.
// Latches one record per PHI2 falling edge into a circular history buffer.
// Exports the latest record and a saturating opcode-fetch counter.
module bus_trace
   import bus_trace_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  phi2,
   input  logic [15:0]           a,
   input  logic [7:0]            d,
   input  logic                  rw,
   input  logic                  sync,
   input  logic                  freeze,
   input  logic                  clear,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [15:0]           rd_a,
   output logic [7:0]            rd_d,
   output logic                  rd_rw,
   output logic                  rd_sync,
   output logic                  rd_valid,
   output logic                  cyc_valid,
   output logic [15:0]           cyc_a,
   output logic [7:0]            cyc_d,
   output logic                  cyc_rw,
   output logic                  cyc_sync,
   output logic [DEPTH_LOG2:0]   fill,
   output logic                  wrapped,
   output logic [15:0]           instr_count
);

   localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

   logic                  phi2_q, seen_low_q;
   logic [REC_W-1:0]      shadow_q, cyc_rec_q, ram_rd;
   logic                  cyc_valid_q, rd_valid_q, wrapped_q, wrapped_d;
   logic [DEPTH_LOG2-1:0] wp_q, wp_d, rd_addr;
   logic [DEPTH_LOG2:0]   fill_q, fill_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  fall, we, full;

   // seen_low_q masks the first fall after reset, so a cycle that was
   // already under way when reset was released never commits.
   assign fall    = phi2_q & ~phi2 & seen_low_q;
   assign we      = fall & ~freeze & ~clear;
   assign full    = (fill_q == DEPTH);
   assign rd_addr = wp_q - DEPTH_LOG2'(1) - rd_idx;

   // pointer, fill, wrap flag and counter next state; clear wins over a commit
   always_comb begin
      wp_d      = wp_q;
      fill_d    = fill_q;
      wrapped_d = wrapped_q;
      cnt_d     = cnt_q;
      if (clear) begin
         wp_d      = '0;
         fill_d    = '0;
         wrapped_d = 1'b0;
         cnt_d     = '0;
      end else if (fall && !freeze) begin
         wp_d      = wp_q + DEPTH_LOG2'(1);
         fill_d    = full ? fill_q : fill_q + 1'b1;
         wrapped_d = wrapped_q | full;
         if (shadow_q[REC_SYNC] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   // edge detect, shadow capture, latest-record export and state update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phi2_q      <= 1'b0;
         seen_low_q  <= 1'b0;
         shadow_q    <= '0;
         cyc_rec_q   <= '0;
         cyc_valid_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         wp_q        <= '0;
         fill_q      <= '0;
         wrapped_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         phi2_q      <= phi2;
         if (!phi2) seen_low_q <= 1'b1;
         // Shadow lags the bus by one clk, so the record predates the falling edge.
         if (phi2)  shadow_q <= pack_rec(a, d, rw, sync);
         if (fall)  cyc_rec_q <= shadow_q;
         cyc_valid_q <= fall;
         rd_valid_q  <= ({1'b0, rd_idx} < fill_q);
         wp_q        <= wp_d;
         fill_q      <= fill_d;
         wrapped_q   <= wrapped_d;
         cnt_q       <= cnt_d;
      end
   end

   trace_ram #(.AW(DEPTH_LOG2), .DW(REC_W)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wp_q),
      .wdata (shadow_q),
      .raddr (rd_addr),
      .rdata (ram_rd)
   );

   assign rd_a        = ram_rd[REC_A +: 16];
   assign rd_d        = ram_rd[REC_D +: 8];
   assign rd_rw       = ram_rd[REC_RW];
   assign rd_sync     = ram_rd[REC_SYNC];
   assign rd_valid    = rd_valid_q;
   assign cyc_valid   = cyc_valid_q;
   assign cyc_a       = cyc_rec_q[REC_A +: 16];
   assign cyc_d       = cyc_rec_q[REC_D +: 8];
   assign cyc_rw      = cyc_rec_q[REC_RW];
   assign cyc_sync    = cyc_rec_q[REC_SYNC];
   assign fill        = fill_q;
   assign wrapped     = wrapped_q;
   assign instr_count = cnt_q;

endmodule
